// File: rtl/vram_arb_pkg.sv
// Shared types and the VDP byte-address to controller word-address mapping.
`timescale 1ns/1ps
package vram_arb_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

  typedef enum logic [1:0] {G_NONE, G_VDP, G_AUX, G_REF} grant_t;

  typedef struct packed {
    logic [15:0] addr;  // word address (byte address / 2)
    logic [1:0]  wdm;   // 1 = byte masked; upper bit masks the high byte
  } vdp_map_t;

  // Even byte addresses land in the low byte lane, odd ones in the high lane.
  function automatic vdp_map_t vdp_to_mc(input logic [16:0] byte_addr);
    vdp_map_t m;
    m.addr = byte_addr[16:1];
    m.wdm  = {~byte_addr[0], byte_addr[0]};
    return m;
  endfunction

endpackage

// File: rtl/vram_refresh_timer.sv
// Refresh age counter: saturating, held at zero while the controller is down,
// cleared when a refresh grant completes.
`timescale 1ns/1ps
module vram_refresh_timer #(
  parameter int REFRESH_CYCLES = 1600,
  parameter int REFRESH_SLACK  = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic pending,
  output logic urgent,
  output logic early
);

  localparam int CNT_MAX = REFRESH_CYCLES + REFRESH_SLACK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MAX_C   = CW'(CNT_MAX);
  localparam logic [CW-1:0] PEND_C  = CW'(REFRESH_CYCLES);
  localparam logic [CW-1:0] EARLY_C = CW'(REFRESH_CYCLES / 2);

  logic [CW-1:0] count_q, count_d;

  // Next count: zero while disabled or on completed refresh, else saturating increment.
  always_comb begin
    count_d = count_q;
    if (!enable || clear) begin
      count_d = '0;
    end else if (count_q != MAX_C) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pending = (count_q >= PEND_C);
  assign urgent  = (count_q >= MAX_C);
  assign early   = (count_q >= EARLY_C);

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the SDRAM controller between VDP, an auxiliary 16-bit port and refresh.
`timescale 1ns/1ps
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W         = 22,
  parameter int REFRESH_CYCLES = 1600,
  parameter int REFRESH_SLACK  = 200,
  parameter int BUSY_TIMEOUT   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vdp_req,
  input  logic              vdp_wr,
  input  logic [16:0]       vdp_addr,
  input  logic [7:0]        vdp_din,
  output logic [15:0]       vdp_dout,
  output logic              vdp_ack,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [15:0]       aux_din,
  input  logic [1:0]        aux_wdm,
  output logic [15:0]       aux_dout,
  output logic              aux_ack,
  input  logic              refresh_hint,
  output logic              mc_read,
  output logic              mc_write,
  output logic              mc_refresh,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [15:0]       mc_din,
  output logic [1:0]        mc_wdm,
  input  logic [15:0]       mc_dout,
  input  logic              mc_busy,
  input  logic              mc_enabled,
  output logic              timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [1:0]        wdm_q, wdm_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       vdp_dout_q, vdp_dout_d;
  logic [15:0]       aux_dout_q, aux_dout_d;

  logic     capture;
  logic     ref_clear;
  logic     ref_pending, ref_urgent, ref_early;
  vdp_map_t vdp_map;

  assign vdp_map = vdp_to_mc(vdp_addr);

  vram_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .REFRESH_SLACK  (REFRESH_SLACK)
  ) u_refresh_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (mc_enabled),
    .clear   (ref_clear),
    .pending (ref_pending),
    .urgent  (ref_urgent),
    .early   (ref_early)
  );

  // Next-state, grant selection with command latching, busy handshake and read capture.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    din_d         = din_q;
    wdm_d         = wdm_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    vdp_dout_d    = vdp_dout_q;
    aux_dout_d    = aux_dout_q;
    capture       = 1'b0;
    ref_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mc_enabled && !mc_busy) begin
          if (ref_urgent) begin
            grant_d = G_REF;
            wr_d    = 1'b0;
            state_d = ISSUE;
          end else if (vdp_req) begin
            grant_d = G_VDP;
            wr_d    = vdp_wr;
            addr_d  = ADDR_W'(vdp_map.addr);
            din_d   = {vdp_din, vdp_din};
            wdm_d   = vdp_map.wdm;
            state_d = ISSUE;
          end else if (aux_req) begin
            grant_d = G_AUX;
            wr_d    = aux_wr;
            addr_d  = aux_addr;
            din_d   = aux_din;
            wdm_d   = aux_wdm;
            state_d = ISSUE;
          end else if (ref_pending || (refresh_hint && ref_early)) begin
            grant_d = G_REF;
            wr_d    = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (mc_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          // Controller never acknowledged the command: give up, still complete the request.
          timeout_err_d = 1'b1;
          capture       = 1'b1;
          state_d       = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!mc_busy) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ref_clear = (grant_q == G_REF);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture && !wr_q) begin
      if (grant_q == G_VDP) vdp_dout_d = mc_dout;
      if (grant_q == G_AUX) aux_dout_d = mc_dout;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= G_NONE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      wdm_q         <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      vdp_dout_q    <= '0;
      aux_dout_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      wdm_q         <= wdm_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      vdp_dout_q    <= vdp_dout_d;
      aux_dout_q    <= aux_dout_d;
    end
  end

  assign mc_read     = (state_q == ISSUE) && (grant_q != G_REF) && !wr_q;
  assign mc_write    = (state_q == ISSUE) && (grant_q != G_REF) && wr_q;
  assign mc_refresh  = (state_q == ISSUE) && (grant_q == G_REF);
  assign mc_addr     = addr_q;
  assign mc_din      = din_q;
  assign mc_wdm      = wdm_q;
  assign vdp_ack     = (state_q == DONE) && (grant_q == G_VDP);
  assign aux_ack     = (state_q == DONE) && (grant_q == G_AUX);
  assign vdp_dout    = vdp_dout_q;
  assign aux_dout    = aux_dout_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small busy-pulse controller model and a
// command scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vdp_req, vdp_wr;
  logic [16:0] vdp_addr;
  logic [7:0]  vdp_din;
  logic [15:0] vdp_dout;
  logic        vdp_ack;
  logic        aux_req, aux_wr;
  logic [21:0] aux_addr;
  logic [15:0] aux_din;
  logic [1:0]  aux_wdm;
  logic [15:0] aux_dout;
  logic        aux_ack;
  logic        refresh_hint;
  logic        mc_read, mc_write, mc_refresh;
  logic [21:0] mc_addr;
  logic [15:0] mc_din;
  logic [1:0]  mc_wdm;
  logic [15:0] mc_dout;
  logic        mc_busy;
  logic        mc_enabled;
  logic        timeout_err;

  // controller model knobs
  int          busy_len;
  logic        mute;
  int          busy_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_cmd  = 0;
  int n_ref  = 0;
  int n_vack = 0;
  int n_aack = 0;
  logic sb_on;

  typedef struct packed {
    logic        wr;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  wdm;
  } exp_t;
  exp_t sb[$];

  vram_arbiter #(
    .ADDR_W         (22),
    .REFRESH_CYCLES (16),
    .REFRESH_SLACK  (4),
    .BUSY_TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vdp_req      (vdp_req),
    .vdp_wr       (vdp_wr),
    .vdp_addr     (vdp_addr),
    .vdp_din      (vdp_din),
    .vdp_dout     (vdp_dout),
    .vdp_ack      (vdp_ack),
    .aux_req      (aux_req),
    .aux_wr       (aux_wr),
    .aux_addr     (aux_addr),
    .aux_din      (aux_din),
    .aux_wdm      (aux_wdm),
    .aux_dout     (aux_dout),
    .aux_ack      (aux_ack),
    .refresh_hint (refresh_hint),
    .mc_read      (mc_read),
    .mc_write     (mc_write),
    .mc_refresh   (mc_refresh),
    .mc_addr      (mc_addr),
    .mc_din       (mc_din),
    .mc_wdm       (mc_wdm),
    .mc_dout      (mc_dout),
    .mc_busy      (mc_busy),
    .mc_enabled   (mc_enabled),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Controller model: busy rises the cycle after a command and lasts busy_len cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
    end else if ((mc_read || mc_write || mc_refresh) && !mute) begin
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign mc_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; outputs sampled on the falling edge, commands checked against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (vdp_ack) n_vack++;
    if (aux_ack) n_aack++;
    if (mc_read || mc_write || mc_refresh) begin
      chk("cmd_onehot", 32'($countones({mc_read, mc_write, mc_refresh})), 32'd1);
      chk("cmd_while_busy", {31'd0, mc_busy}, 32'd0);
      if (mc_refresh) begin
        n_ref++;
        $display("cyc %0d: refresh", cyc);
      end else begin
        n_cmd++;
        $display("cyc %0d: %s addr=%h din=%h wdm=%b", cyc, mc_write ? "write" : "read",
                 mc_addr, mc_din, mc_wdm);
        if (sb_on) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_cmd", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("cmd_wr", {31'd0, mc_write}, {31'd0, e.wr});
            chk("cmd_addr", {10'd0, mc_addr}, {10'd0, e.addr});
            if (e.wr) begin
              chk("cmd_din", {16'd0, mc_din}, {16'd0, e.din});
              chk("cmd_wdm", {30'd0, mc_wdm}, {30'd0, e.wdm});
            end
          end
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vdp_req = 1'b0; vdp_wr = 1'b0; vdp_addr = '0; vdp_din = '0;
    aux_req = 1'b0; aux_wr = 1'b0; aux_addr = '0; aux_din = '0; aux_wdm = '0;
    refresh_hint = 1'b0; mc_enabled = 1'b0; mc_dout = '0;
    mute = 1'b0; busy_len = 1; sb_on = 1'b1;
    sb.delete();
    ticks(2);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input logic is_vdp, output int lat);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (is_vdp ? vdp_ack : aux_ack) begin
        lat = n;
        break;
      end
    end
    chk(is_vdp ? "vdp_ack_seen" : "aux_ack_seen", {31'd0, lat != 0}, 32'd1);
  endtask

  task automatic vdp_txn(input logic wr, input logic [16:0] a, input logic [7:0] d,
                         input logic [21:0] ea, input logic [15:0] ed, input logic [1:0] ew,
                         input logic [15:0] edout, output int lat);
    vdp_wr = wr; vdp_addr = a; vdp_din = d; vdp_req = 1'b1;
    sb.push_back('{wr, ea, ed, ew});
    wait_ack(1'b1, lat);
    vdp_req = 1'b0;
    if (!wr) chk("vdp_dout", {16'd0, vdp_dout}, {16'd0, edout});
    tick();
    chk("vdp_ack_one_cycle", {31'd0, vdp_ack}, 32'd0);
  endtask

  task automatic aux_txn(input logic wr, input logic [21:0] a, input logic [15:0] d,
                         input logic [1:0] m, input logic [15:0] edout);
    int lat;
    aux_wr = wr; aux_addr = a; aux_din = d; aux_wdm = m; aux_req = 1'b1;
    sb.push_back('{wr, a, d, m});
    wait_ack(1'b0, lat);
    aux_req = 1'b0;
    if (!wr) chk("aux_dout", {16'd0, aux_dout}, {16'd0, edout});
    tick();
    chk("aux_ack_one_cycle", {31'd0, aux_ack}, 32'd0);
  endtask

  initial begin
    int lat, r1, r2, reads, vack_n, aack_n, base;

    // ---- reset values
    do_reset();
    reset_n = 1'b0;
    tick();
    chk("rst_cmds", {29'd0, mc_read, mc_write, mc_refresh}, 32'd0);
    chk("rst_acks", {30'd0, vdp_ack, aux_ack}, 32'd0);
    chk("rst_mc_addr", {10'd0, mc_addr}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset_n = 1'b1;

    // ---- VDP read / writes
    do_reset();
    mc_enabled = 1'b1;
    mc_dout = 16'hBEEF;
    vdp_txn(1'b0, 17'h1_2345, 8'h00, 22'h0091A2, 16'h0, 2'b00, 16'hBEEF, lat);
    chk("vdp_read_latency", 32'(lat), 32'd4);
    vdp_txn(1'b1, 17'h00010, 8'h5A, 22'h000008, 16'h5A5A, 2'b10, 16'h0, lat);
    vdp_txn(1'b1, 17'h00011, 8'h3C, 22'h000008, 16'h3C3C, 2'b01, 16'h0, lat);
    chk("sb_drained_1", 32'(sb.size()), 32'd0);

    // ---- simultaneous VDP and aux: VDP first
    do_reset();
    mc_enabled = 1'b1;
    busy_len = 2;
    mc_dout = 16'h4242;
    vdp_wr = 1'b0; vdp_addr = 17'h00020; vdp_req = 1'b1;
    aux_wr = 1'b1; aux_addr = 22'h3FFFFF; aux_din = 16'h9876; aux_wdm = 2'b00; aux_req = 1'b1;
    sb.push_back('{1'b0, 22'h000010, 16'h0, 2'b00});
    sb.push_back('{1'b1, 22'h3FFFFF, 16'h9876, 2'b00});
    vack_n = 0; aack_n = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (vdp_ack) begin vack_n = n; vdp_req = 1'b0; end
      if (aux_ack) begin aack_n = n; aux_req = 1'b0; end
      if (vack_n != 0 && aack_n != 0) break;
    end
    chk("arb_vdp_acked", {31'd0, vack_n != 0}, 32'd1);
    chk("arb_aux_after_vdp", {31'd0, aack_n > vack_n}, 32'd1);
    chk("arb_vdp_dout", {16'd0, vdp_dout}, 32'h4242);
    mc_dout = 16'hCAFE;
    aux_txn(1'b0, 22'h00ABCD, 16'h0, 2'b11, 16'hCAFE);
    chk("vdp_dout_held", {16'd0, vdp_dout}, 32'h4242);
    chk("sb_drained_2", 32'(sb.size()), 32'd0);

    // ---- pending refresh with no requests, then counter cleared by completion
    do_reset();
    mc_enabled = 1'b1;
    r1 = 0; r2 = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (mc_refresh) begin
        if (r1 == 0) r1 = n;
        else if (r2 == 0) r2 = n;
      end
    end
    chk("refresh_pending_cycle", 32'(r1), 32'd17);
    chk("refresh_second_cycle", 32'(r2), 32'd38);

    // ---- urgent refresh preempts continuous VDP traffic
    do_reset();
    sb_on = 1'b0;
    vdp_wr = 1'b0; vdp_addr = 17'h0; vdp_req = 1'b1;
    mc_enabled = 1'b1;
    reads = 0; r1 = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (mc_read) reads++;
      if (mc_refresh) begin r1 = n; break; end
    end
    chk("refresh_urgent_cycle", 32'(r1), 32'd21);
    chk("reads_before_urgent", 32'(reads), 32'd4);
    vdp_req = 1'b0;
    ticks(6);
    sb_on = 1'b1;

    // ---- early refresh on idle hint
    do_reset();
    mc_enabled = 1'b1;
    r1 = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (mc_refresh && r1 == 0) r1 = n;
      if (n == 8) refresh_hint = 1'b1;
    end
    chk("refresh_early_cycle", 32'(r1), 32'd9);
    refresh_hint = 1'b0;

    // ---- busy timeout, then normal service
    do_reset();
    mc_enabled = 1'b1;
    mute = 1'b1;
    mc_dout = 16'h1111;
    vdp_txn(1'b0, 17'h00100, 8'h00, 22'h000080, 16'h0, 2'b00, 16'h1111, lat);
    chk("timeout_latency", 32'(lat), 32'd10);
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    mute = 1'b0;
    mc_dout = 16'h2222;
    vdp_txn(1'b0, 17'h00202, 8'h00, 22'h000101, 16'h0, 2'b00, 16'h2222, lat);
    chk("after_timeout_latency", 32'(lat), 32'd4);
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

    // ---- reset asserted mid-transaction (WAIT_LO)
    busy_len = 4;
    mc_dout = 16'h7777;
    vdp_txn(1'b0, 17'h00000, 8'h00, 22'h000000, 16'h0, 2'b00, 16'h7777, lat);
    vdp_wr = 1'b1; vdp_addr = 17'h00004; vdp_din = 8'hA5; vdp_req = 1'b1;
    sb.push_back('{1'b1, 22'h000002, 16'hA5A5, 2'b10});
    ticks(3);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cmds", {29'd0, mc_read, mc_write, mc_refresh}, 32'd0);
    chk("rst_mid_acks", {30'd0, vdp_ack, aux_ack}, 32'd0);
    chk("rst_mid_vdp_dout", {16'd0, vdp_dout}, 32'd0);
    chk("rst_mid_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_mid_fields", {8'd0, mc_din, 6'd0, mc_wdm}, 32'd0);
    chk("rst_mid_addr", {10'd0, mc_addr}, 32'd0);
    vdp_req = 1'b0;
    base = n_vack;
    ticks(2);
    reset_n = 1'b1;
    ticks(10);
    chk("rst_mid_no_ack", 32'(n_vack - base), 32'd0);

    // ---- controller not enabled: request stays pending
    do_reset();
    mc_dout = 16'hABCD;
    vdp_wr = 1'b0; vdp_addr = 17'h00006; vdp_req = 1'b1;
    sb.push_back('{1'b0, 22'h000003, 16'h0, 2'b00});
    base = n_cmd + n_ref;
    ticks(10);
    chk("disabled_no_cmds", 32'(n_cmd + n_ref - base), 32'd0);
    mc_enabled = 1'b1;
    tick();
    chk("enable_first_cycle", {31'd0, mc_read}, 32'd1);
    wait_ack(1'b1, lat);
    vdp_req = 1'b0;
    chk("enable_vdp_dout", {16'd0, vdp_dout}, 32'hABCD);
    tick();
    chk("sb_drained_3", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sits between the VDP VRAM port and the SDRAM memory_controller.
- Shares the controller among three clients:
  - VDP pixel/CPU slot accesses (highest priority);
  - an auxiliary 16-bit requester, used for the planned blitter/CPU direct path;
  - the SDRAM refresh scheduler.
- Owns refresh timing, so refresh no longer depends only on VDP idle clock phases.
- Converts the VDP 17-bit byte address into the controller's word address plus byte mask.

Parameters:
- ADDR_W, 22, memory_controller word-address width.
- REFRESH_CYCLES, 1600, clk cycles after which a refresh becomes pending (soft deadline).
- REFRESH_SLACK, 200, extra cycles after REFRESH_CYCLES before a pending refresh becomes urgent.
- BUSY_TIMEOUT, 8, cycles to wait for mc_busy to rise after a command before aborting.

Ports:
- clk, in, 1, controller clock; same domain as memory_controller.clk.
- reset_n, in, 1, asynchronous active-low reset.
- vdp_req, in, 1, level; held until vdp_ack.
- vdp_wr, in, 1, 1 = write, 0 = read.
- vdp_addr, in, 17, byte address.
- vdp_din, in, 8, write byte.
- vdp_dout, out, 16, read word.
- vdp_ack, out, 1, one-cycle completion pulse.
- aux_req, in, 1, level; held until aux_ack.
- aux_wr, in, 1, 1 = write, 0 = read.
- aux_addr, in, ADDR_W, word address.
- aux_din, in, 16, write word.
- aux_wdm, in, 2, byte mask (1 = byte masked).
- aux_dout, out, 16, read word.
- aux_ack, out, 1, one-cycle completion pulse.
- refresh_hint, in, 1, VDP idle window (~DLClk & ~DHClk); permits early refresh.
- mc_read, out, 1, one-cycle read command.
- mc_write, out, 1, one-cycle write command.
- mc_refresh, out, 1, one-cycle refresh command.
- mc_addr, out, ADDR_W, command address.
- mc_din, out, 16, command write data.
- mc_wdm, out, 2, command byte mask.
- mc_dout, in, 16, controller read data.
- mc_busy, in, 1, controller busy.
- mc_enabled, in, 1, controller initialised.
- timeout_err, out, 1, sticky; set on busy timeout.

Behaviour:
- Reset values (async on reset_n low, any state):
  - all outputs 0; state IDLE; refresh counter 0; timeout_err 0.
  - Any in-flight request is dropped with no ack; the requester must re-present it.
- mc_enabled = 0:
  - stay in IDLE; issue no commands; hold the refresh counter at 0.
  - Requests stay pending (no ack).
- States: IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> DONE -> IDLE.
- Grant evaluation, only in IDLE with mc_busy = 0, in priority order:
  1. urgent refresh (counter ≥ REFRESH_CYCLES + REFRESH_SLACK);
  2. vdp_req;
  3. aux_req;
  4. pending refresh (counter ≥ REFRESH_CYCLES);
  5. early refresh (refresh_hint & counter ≥ REFRESH_CYCLES/2).
- Grant registers command fields; ISSUE drives exactly one of mc_read/mc_write/mc_refresh for one cycle.
- VDP mapping:
  - mc_addr = zero-extended vdp_addr[16:1];
  - mc_din = {vdp_din, vdp_din};
  - mc_wdm = {~vdp_addr[0], vdp_addr[0]}.
- Aux fields pass through unchanged.
- WAIT_HI:
  - mc_busy = 1 -> WAIT_LO.
  - BUSY_TIMEOUT cycles with no rise -> set timeout_err, go to DONE; data = last mc_dout.
- WAIT_LO: mc_busy = 0 -> DONE, capturing mc_dout into the granted client's dout register (reads only).
- DONE:
  - one-cycle ack to the granted client (none for refresh);
  - refresh grant clears the counter here.
- Latency:
  - minimum 4 cycles grant-to-ack (IDLE, ISSUE, WAIT_HI with busy seen next cycle, WAIT_LO 1 cycle, DONE), plus the controller busy time.
  - A new grant is possible the cycle after DONE.
- dout registers hold their value until the next read completes for that client.
- Refresh counter:
  - increments every cycle while mc_enabled;
  - saturates at REFRESH_CYCLES + REFRESH_SLACK;
  - cleared only by a completed refresh grant.
- Simultaneous vdp_req and aux_req: VDP wins; aux is served at the next IDLE with no VDP request.
- A request that drops before its ack is still completed; its ack is ignored by the requester.
- Write data and address are sampled at grant; later input changes have no effect.

Decomposition:
- Package vram_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE);
  - grant enum (G_NONE, G_VDP, G_AUX, G_REF);
  - vdp_to_mc address/mask function.
- Sub-module vram_refresh_timer:
  - counter, saturation, pending/urgent/early flags;
  - clear input driven on refresh completion.

Test Plan:
- VDP read, vdp_addr = 17'h1_2345, mc_dout = 16'hBEEF -> mc_read pulses once with mc_addr = 22'h0091A2; vdp_dout = 16'hBEEF with a 1-cycle vdp_ack.
- VDP write, vdp_addr = 17'h00010, vdp_din = 8'h5A -> mc_write with mc_din = 16'h5A5A, mc_wdm = 2'b10.
- Odd-address VDP write -> mc_wdm = 2'b01.
- vdp_req and aux_req asserted in the same cycle:
  - VDP is acked first, then aux (aux_addr = 22'h3FFFFF, aux_wdm = 2'b00 passed through);
  - no overlap of mc_* commands.
- Refresh with REFRESH_CYCLES = 16, REFRESH_SLACK = 4:
  - with refresh_hint = 0 and no requests, mc_refresh issues at counter 16;
  - with continuous vdp_req, refresh preempts VDP at counter 20;
  - with refresh_hint = 1 from cycle 8, refresh issues at counter 8.
- mc_busy never rises -> timeout_err = 1 after 8 WAIT_HI cycles; vdp_ack still pulses; the next request is served normally.
- Assert reset_n low in WAIT_LO -> all outputs 0 immediately, no ack.
- Hold mc_enabled = 0 with vdp_req high -> no mc commands; servicing begins 1 cycle after mc_enabled rises.
